// File: rtl/dlfloat_mac_host_link.sv
// Host-side link for the DLfloat MAC byte interface.
//
// Accepts one operand pair per valid/ready handshake and drives it onto the
// MAC's 16-bit input bus as two phase-aligned beats (A on ph=0, B on ph=1).
// After a fixed latency it reassembles the MAC's serialized result bytes
// (MSB byte, then LSB byte) into a 16-bit word and offers that word on a
// valid/ready result port. The block does no arithmetic; it only moves data.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   op_valid   operand pair offered
//   op_ready   block accepts an operand pair (IDLE and not in reset)
//   op_a/op_b  DLfloat operands A and B
//   bus_out    registered MAC input bus; zero outside the two beat cycles
//   c_byte     serialized MAC result byte stream
//   res_valid  result word available
//   res_ready  consumer takes the result
//   res_data   reassembled result word
//   res_nan    res_data == 16'hFFFF
//   busy       FSM is not idle
module dlfloat_mac_host_link #(
  parameter int unsigned RESULT_LAT = 4,
  parameter bit          MSB_PHASE  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] bus_out,
  input  logic [7:0]  c_byte,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_nan,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StBeatA,
    StBeatB,
    StWait,
    StHold
  } state_t;

  state_t      state;
  logic        ph;
  logic [15:0] a_lat;
  logic [15:0] b_lat;
  logic [7:0]  msb_hold;
  logic [7:0]  lat_cnt;

  // rst is checked directly so op_ready drops the instant reset asserts.
  assign op_ready = (state == StIdle) && !rst;
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      ph        <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      msb_hold  <= '0;
      lat_cnt   <= '0;
      bus_out   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_nan   <= 1'b0;
    end else begin
      // ph mirrors the MAC's beat phase, which starts counting at reset release.
      ph      <= ~ph;
      bus_out <= '0;
      unique case (state)
        StIdle: begin
          if (op_valid) begin
            a_lat <= op_a;
            b_lat <= op_b;
            // Beat A must land on ph=0; if the next cycle is ph=1, burn one cycle.
            if (ph) begin
              state   <= StBeatA;
              bus_out <= op_a;
            end else begin
              state <= StSync;
            end
          end
        end
        StSync: begin
          state   <= StBeatA;
          bus_out <= a_lat;
        end
        StBeatA: begin
          state   <= StBeatB;
          bus_out <= b_lat;
        end
        StBeatB: begin
          state   <= StWait;
          lat_cnt <= 8'(RESULT_LAT);
        end
        StWait: begin
          if (lat_cnt != 8'd0) begin
            lat_cnt <= lat_cnt - 8'd1;
          end
          if (ph == MSB_PHASE) begin
            msb_hold <= c_byte;
          end else if (lat_cnt == 8'd0) begin
            // Capture only on an LSB cycle so the word is never split across pairs.
            res_data  <= {msb_hold, c_byte};
            res_nan   <= ({msb_hold, c_byte} == 16'hFFFF);
            res_valid <= 1'b1;
            state     <= StHold;
          end
        end
        StHold: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_host_link.sv
// Self-checking bench for dlfloat_mac_host_link: a transaction-level model
// schedules beat and capture cycles from the accept cycle and phase, and a
// negedge process compares every output each cycle. Directed steps pin the
// model with literal expectations; a random phase follows.
module tb_dlfloat_mac_host_link;

  localparam int unsigned L   = 4;
  localparam bit          MSB = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] bus_out;
  logic [7:0]  c_byte = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_nan;
  logic        busy;

  dlfloat_mac_host_link #(.RESULT_LAT(L), .MSB_PHASE(MSB)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .bus_out   (bus_out),
    .c_byte    (c_byte),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_nan   (res_nan),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int byte_mode = 0;  // 0 random, 1 MSB=40/LSB=00, 2 all FF

  // Model state: cycle index since reset release and expected phase.
  int          cyc = 0;
  bit          mph = 1'b0;
  bit          m_active = 1'b0;
  bit          m_hold = 1'b0;
  int          acc_cyc, a_cyc, b_cyc, ws_cyc, cap_cyc;
  logic [15:0] la = '0, lb = '0, m_res = '0;
  logic [7:0]  m_msb = '0;
  bit          m_nan = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, updated at each active edge or reset assertion.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; mph = 1'b0; m_active = 1'b0; m_hold = 1'b0;
      m_res = '0; m_nan = 1'b0; m_msb = '0;
    end else begin
      if (m_hold) begin
        if (res_ready) m_hold = 1'b0;
      end else if (m_active) begin
        if (cyc >= ws_cyc && mph == MSB) m_msb = c_byte;
        if (cyc == cap_cyc) begin
          m_res    = {m_msb, c_byte};
          m_nan    = (m_res == 16'hFFFF);
          m_active = 1'b0;
          m_hold   = 1'b1;
        end
      end else if (op_valid) begin
        int z;
        bit phz;
        la = op_a; lb = op_b;
        acc_cyc = cyc;
        a_cyc   = cyc + (mph ? 1 : 2);
        b_cyc   = a_cyc + 1;
        ws_cyc  = b_cyc + 1;
        z       = ws_cyc + int'(L);
        phz     = mph ^ bit'((z - acc_cyc) & 1);
        cap_cyc = z + ((phz == MSB) ? 1 : 0);
        m_active = 1'b1;
      end
      cyc++;
      mph = ~mph;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [15:0] eb;
    @(negedge clk);
    eb = '0;
    if (m_active && cyc == a_cyc) eb = la;
    if (m_active && cyc == b_cyc) eb = lb;
    check("bus_out", 32'(bus_out), 32'(eb));
    check("busy", 32'(busy), 32'(m_active || m_hold));
    check("op_ready", 32'(op_ready), 32'(!rst && !m_active && !m_hold));
    check("res_valid", 32'(res_valid), 32'(m_hold));
    check("res_data", 32'(res_data), 32'(m_res));
    check("res_nan", 32'(res_nan), 32'(m_nan));
  end

  // Advance to just after the falling edge and drive the MAC byte stream.
  task automatic step();
    @(negedge clk);
    #1;
    case (byte_mode)
      1:       c_byte = (mph == MSB) ? 8'h40 : 8'h00;
      2:       c_byte = 8'hFF;
      default: c_byte = 8'($urandom);
    endcase
  endtask

  // Offer a pair on a cycle with the requested phase; returns one cycle after accept.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit want_ph);
    int n = 0;
    while (!(mph == want_ph && op_ready) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(n), 32'(0));
    op_a = a; op_b = b; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom);
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (!res_valid && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("res_valid_timeout", 32'(res_valid), 32'(1));
  endtask

  initial begin
    int n;
    // 1: reset
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_op_ready", 32'(op_ready), 32'(0));
      check("rst_res_valid", 32'(res_valid), 32'(0));
      check("rst_bus_out", 32'(bus_out), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end
    rst = 1'b0;
    byte_mode = 1;
    step();
    check("post_rst_op_ready", 32'(op_ready), 32'(1));
    step();

    // 2 and 4: ph=1 accept, no SYNC, result 4000 after 9 cycles
    send(16'h3E00, 16'h4000, 1'b1);
    check("beat_a_nosync", 32'(bus_out), 32'h3E00);
    step();
    check("beat_b_nosync", 32'(bus_out), 32'h4000);
    step();
    check("bus_idle_after_b", 32'(bus_out), 32'h0);
    wait_rv(n);
    check("latency_ph1", 32'(n), 32'(6));
    check("res_data_4000", 32'(res_data), 32'h4000);
    check("res_nan_0", 32'(res_nan), 32'(0));

    // 5: backpressure with op_valid pulses
    for (int i = 0; i < 10; i++) begin
      op_valid = i[0];
      step();
      check("hold_res_valid", 32'(res_valid), 32'(1));
      check("hold_res_data", 32'(res_data), 32'h4000);
      check("hold_op_ready", 32'(op_ready), 32'(0));
      check("hold_bus_out", 32'(bus_out), 32'h0);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("release_res_valid", 32'(res_valid), 32'(0));
    check("release_op_ready", 32'(op_ready), 32'(1));

    // 3: ph=0 accept goes through SYNC
    send(16'h3E00, 16'h4000, 1'b0);
    check("sync_bus_zero", 32'(bus_out), 32'h0);
    step();
    check("beat_a_sync", 32'(bus_out), 32'h3E00);
    step();
    check("beat_b_sync", 32'(bus_out), 32'h4000);
    wait_rv(n);
    check("latency_ph0", 32'(n), 32'(7));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // 6: NaN result, then reset during WAIT
    byte_mode = 2;
    send(16'h1111, 16'h2222, 1'b1);
    wait_rv(n);
    check("res_data_ffff", 32'(res_data), 32'hFFFF);
    check("res_nan_1", 32'(res_nan), 32'(1));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    send(16'h5555, 16'h6666, 1'b1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_bus_out", 32'(bus_out), 32'(0));
    check("midrst_op_ready", 32'(op_ready), 32'(0));
    check("midrst_res_data", 32'(res_data), 32'(0));
    step();
    step();
    rst = 1'b0;
    step();
    // ph restarted at 0, so this cycle is ph=1 and accept skips SYNC.
    op_a = 16'h1234; op_b = 16'h5678; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("ph_restart_beat_a", 32'(bus_out), 32'h1234);
    for (int i = 0; i < 20; i++) step();
    res_ready = 1'b1;
    step();

    // Random phase
    byte_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      op_valid  = 1'($urandom);
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      res_ready = ($urandom % 3) == 0;
      rst       = ($urandom % 250) == 0;
      step();
    end
    rst = 1'b0;
    op_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
